cal_table_sequencer: RTL and testbench

Autonomous successor to the single-bit calibration manager. Runs a complete LED-ID calibration by itself: it clears the per-pixel calibration table, then for each ID bit (MSB first) requests the LED ID pattern, waits out settle frames, and captures one thresholded camera frame into the table by read-modify-write. It sits between the LED ID pattern driver and the camera frame stream. A second read port serves the HDMI overlay.

---
 rtl/cal_table_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cal_table_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_table_sequencer.sv
// cal_table_sequencer
//   Runs a complete LED-ID calibration on its own. It clears the per-pixel
//   calibration table, then for each ID bit (MSB first) asks the pattern
//   driver to show that bit, discards settle frames, and folds one
//   thresholded camera frame into the table by read-modify-write.
//   A second, always-live read port serves the HDMI overlay.
//
// Optional feature (compile-time macro AMBIENT_SUBTRACT_EN):
//   Adds a baseline RAM captured from a dark frame before the first bit.
//   Bit decisions then use sat_sub(pix_data, baseline) instead of raw pix_data.
//   Without the macro, show_dark is tied low and no baseline RAM exists.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, abort      one-cycle control pulses
//   threshold         brightness threshold, sampled on an accepted start
//   show_req          pulse: display ID bit show_bit_index
//   show_dark         pulse: display all LEDs off (feature build only)
//   show_bit_index    bit currently shown or captured
//   show_done         pattern driver has latched the requested frame
//   pix_valid/pix_frame_start/pix_addr/pix_data   camera pixel stream
//   rd_addr, rd_data  overlay read port, 2-cycle latency
//   busy, done        status levels
//   dbg_state         current FSM state encoding, for observation only
//
// Pixel stream handshake: there is no back-pressure. A pixel is transferred
// on every cycle pix_valid is high; pix_frame_start, pix_addr and pix_data
// are meaningful only in those cycles.

module cal_table_sequencer #(
    parameter int NUM_LEDS      = 50,
    parameter int ID_BITS       = $clog2(NUM_LEDS) + 1,
    parameter int NUM_PIXELS    = 360 * 180,
    parameter int PIXEL_WIDTH   = 16,
    parameter int SETTLE_FRAMES = 2,
    localparam int ADDR_W       = $clog2(NUM_PIXELS),
    localparam int BIT_IDX_W    = $clog2(ID_BITS) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PIXEL_WIDTH-1:0] threshold,
    output logic                   show_req,
    output logic                   show_dark,
    output logic [BIT_IDX_W-1:0]   show_bit_index,
    input  logic                   show_done,
    input  logic                   pix_valid,
    input  logic                   pix_frame_start,
    input  logic [ADDR_W-1:0]      pix_addr,
    input  logic [PIXEL_WIDTH-1:0] pix_data,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [ID_BITS-1:0]     rd_data,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_DARK_SHOW, S_SHOW, S_SETTLE,
        S_ARM, S_CAPTURE, S_DRAIN, S_DONE
    } state_t;

    localparam logic [ADDR_W:0]      PIX_CNT     = (ADDR_W + 1)'(NUM_PIXELS);
    localparam logic [ADDR_W-1:0]    LAST_ADDR   = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [BIT_IDX_W-1:0] TOP_BIT     = BIT_IDX_W'(ID_BITS - 1);
    localparam logic [7:0]           LAST_SETTLE = 8'(SETTLE_FRAMES - 1);

    state_t                   state;
    logic [ADDR_W-1:0]        clr_addr;
    logic [7:0]               settle_cnt;
    logic                     drain_cnt;
    logic [PIXEL_WIDTH-1:0]   thr_q;
    logic                     dark_phase;   // current capture fills the baseline

    logic frame_edge;
    logic accept;

    // Capture pipeline: stage 1 holds the issued read, stage 2 writes back.
    logic                     v1, v2;
    logic                     dk1, dk2;
    logic [ADDR_W-1:0]        a1, a2;
    logic [PIXEL_WIDTH-1:0]   d1, d2;
    logic [ID_BITS-1:0]       tbl_q1, tbl_q2;
    logic [PIXEL_WIDTH-1:0]   cmp_val;
    logic                     bit_new;
    logic [ID_BITS:0]         shifted;
    logic [ID_BITS-1:0]       tbl_wdata;

    logic [ID_BITS-1:0]       tbl_mem [NUM_PIXELS];
    logic [ID_BITS-1:0]       rd_q1;

`ifdef AMBIENT_SUBTRACT_EN
    logic [PIXEL_WIDTH-1:0]   base_mem [NUM_PIXELS];
    logic [PIXEL_WIDTH-1:0]   base_q1, base_q2;
    logic                     show_dark_q;
    assign show_dark = show_dark_q;
`else
    assign show_dark = 1'b0;
`endif

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    always_comb begin
        frame_edge = pix_valid && pix_frame_start;
        // The frame-start pixel seen in ARM is itself the first captured pixel.
        accept = pix_valid && ({1'b0, pix_addr} < PIX_CNT) &&
                 (((state == S_ARM) && pix_frame_start) || (state == S_CAPTURE));
    end

    always_comb begin
        cmp_val = d2;
`ifdef AMBIENT_SUBTRACT_EN
        cmp_val = (d2 > base_q2) ? (d2 - base_q2) : '0;
`endif
        bit_new   = (cmp_val > thr_q);
        // New bit enters at the LSB, so the first (MSB) capture ends up on top.
        shifted   = {tbl_q2, bit_new};
        tbl_wdata = shifted[ID_BITS-1:0];
    end

    // Pipeline valids are reset; in-flight writes after an abort may finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= accept;
            v2 <= v1;
        end
    end

    always_ff @(posedge clk) begin
        a1     <= pix_addr;
        d1     <= pix_data;
        dk1    <= dark_phase;
        tbl_q1 <= tbl_mem[pix_addr];
        a2     <= a1;
        d2     <= d1;
        dk2    <= dk1;
        tbl_q2 <= tbl_q1;
`ifdef AMBIENT_SUBTRACT_EN
        base_q1 <= base_mem[pix_addr];
        base_q2 <= base_q1;
`endif
    end

    // Table write port. Clearing wins so a late write left over from an
    // aborted run cannot leave a nonzero entry behind a fresh CLEAR.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            tbl_mem[clr_addr] <= '0;
        end else if (v2 && !dk2) begin
            tbl_mem[a2] <= tbl_wdata;
        end
`ifdef AMBIENT_SUBTRACT_EN
        if (v2 && dk2) begin
            base_mem[a2] <= d2;
        end
`endif
    end

    // Overlay read port: address register stage, then output register.
    always_ff @(posedge clk) begin
        rd_q1   <= tbl_mem[rd_addr];
        rd_data <= rd_q1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            show_req       <= 1'b0;
            show_bit_index <= '0;
            clr_addr       <= '0;
            settle_cnt     <= '0;
            drain_cnt      <= 1'b0;
            thr_q          <= '0;
            dark_phase     <= 1'b0;
`ifdef AMBIENT_SUBTRACT_EN
            show_dark_q    <= 1'b0;
`endif
        end else begin
            show_req <= 1'b0;
`ifdef AMBIENT_SUBTRACT_EN
            show_dark_q <= 1'b0;
`endif
            if (abort && busy) begin
                state      <= S_IDLE;
                dark_phase <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            state    <= S_CLEAR;
                            clr_addr <= '0;
                            thr_q    <= threshold;
                        end
                    end
                    S_CLEAR: begin
                        clr_addr <= clr_addr + 1'b1;
                        if (clr_addr == LAST_ADDR) begin
                            show_bit_index <= TOP_BIT;
`ifdef AMBIENT_SUBTRACT_EN
                            state       <= S_DARK_SHOW;
                            show_dark_q <= 1'b1;
                            dark_phase  <= 1'b1;
`else
                            state    <= S_SHOW;
                            show_req <= 1'b1;
`endif
                        end
                    end
                    S_DARK_SHOW, S_SHOW: begin
                        if (show_done) begin
                            settle_cnt <= '0;
                            state      <= (SETTLE_FRAMES == 0) ? S_ARM : S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (frame_edge) begin
                            if (settle_cnt == LAST_SETTLE) begin
                                state <= S_ARM;
                            end else begin
                                settle_cnt <= settle_cnt + 1'b1;
                            end
                        end
                    end
                    S_ARM, S_CAPTURE: begin
                        if (accept && (pix_addr == LAST_ADDR)) begin
                            state     <= S_DRAIN;
                            drain_cnt <= 1'b0;
                        end else if ((state == S_ARM) && frame_edge) begin
                            state <= S_CAPTURE;
                        end
                    end
                    S_DRAIN: begin
                        drain_cnt <= 1'b1;
                        if (drain_cnt) begin
                            if (dark_phase) begin
                                // Baseline done; first bit index is already on top.
                                dark_phase <= 1'b0;
                                state      <= S_SHOW;
                                show_req   <= 1'b1;
                            end else if (show_bit_index == '0) begin
                                state <= S_DONE;
                            end else begin
                                show_bit_index <= show_bit_index - 1'b1;
                                state          <= S_SHOW;
                                show_req       <= 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cal_table_sequencer.sv
module tb_cal_table_sequencer;

  localparam int IDB    = 3;
  localparam int NPIX   = 20;
  localparam int PW     = 16;
  localparam int SETTLE = 2;
  localparam int AW     = 5;
  localparam int BIW    = 3;

  typedef logic [PW-1:0] frame_t [NPIX];

  logic           clk = 1'b0;
  logic           rst, start, abort, show_done;
  logic [PW-1:0]  threshold;
  logic           show_req, show_dark;
  logic [BIW-1:0] show_bit_index;
  logic           pix_valid, pix_frame_start;
  logic [AW-1:0]  pix_addr, rd_addr;
  logic [PW-1:0]  pix_data;
  logic [IDB-1:0] rd_data;
  logic           busy, done;
  logic [3:0]     dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int show_cnt     = 0;
  int dark_cnt     = 0;
  int show_idx_q[$];
  logic [IDB-1:0] exp_q[$];

  frame_t frame_val [IDB];
  frame_t base_val;
  frame_t bright;

  cal_table_sequencer #(
    .NUM_LEDS(4), .ID_BITS(IDB), .NUM_PIXELS(NPIX),
    .PIXEL_WIDTH(PW), .SETTLE_FRAMES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .threshold(threshold),
    .show_req(show_req), .show_dark(show_dark), .show_bit_index(show_bit_index),
    .show_done(show_done), .pix_valid(pix_valid), .pix_frame_start(pix_frame_start),
    .pix_addr(pix_addr), .pix_data(pix_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / pulse monitors ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (show_req) begin
      show_cnt++;
      show_idx_q.push_back(int'(show_bit_index));
    end
    if (show_dark) dark_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input frame_t vals, input bit gaps, input int count);
    for (int p = 0; p < count; p++) begin
      if (gaps) begin
        int n = $urandom_range(0, 3);
        for (int g = 0; g < n; g++) begin
          if ($urandom_range(0, 1) == 1) begin
            // Out-of-range pixel: must be dropped.
            pix_valid = 1'b1; pix_frame_start = 1'b0;
            pix_addr = AW'($urandom_range(NPIX, 31)); pix_data = '1;
          end else begin
            pix_valid = 1'b0; pix_frame_start = 1'b0;
            pix_addr = AW'($urandom_range(0, 31)); pix_data = PW'($urandom);
          end
          tick();
        end
      end
      pix_valid = 1'b1; pix_frame_start = (p == 0);
      pix_addr = AW'(p); pix_data = vals[p];
      tick();
    end
    pix_valid = 1'b0; pix_frame_start = 1'b0;
  endtask

  task automatic wait_pulse(input bit dark, output bit ok, output int lat);
    ok = 1'b0; lat = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      tick();
      lat++;
      if (dark ? show_dark : show_req) ok = 1'b1;
    end
  endtask

  task automatic pulse_done();
    show_done = 1'b1; tick(); show_done = 1'b0;
  endtask

  // Expected entry: bit j is set when the bit-j capture frame is brighter
  // than the threshold (after baseline removal in the ambient build).
  function automatic logic [IDB-1:0] model_entry(input int p, input int thr);
    logic [IDB-1:0] e = '0;
    for (int j = 0; j < IDB; j++) begin
      int v = int'(frame_val[j][p]);
`ifdef AMBIENT_SUBTRACT_EN
      v = v - int'(base_val[p]);
      if (v < 0) v = 0;
`endif
      if (v > thr) e[j] = 1'b1;
    end
    return e;
  endfunction

  task automatic read_table(input string tag, input int thr);
    for (int p = 0; p < NPIX; p++) exp_q.push_back(model_entry(p, thr));
    for (int p = 0; p < NPIX; p++) begin
      rd_addr = AW'(p);
      tick(); tick();
      check($sformatf("%s_entry%0d", tag, p), 32'(rd_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic run_cal(input int thr, input bit gaps, input int abort_bit, input bit busy_start);
    bit ok;
    int lat;
    int pre;
    int c0;
    threshold = PW'(thr); start = 1'b1; tick(); start = 1'b0;
    threshold = PW'($urandom);   // must not matter after start
    check("start_done_low", 32'(done), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    pre = 1;
    if (busy_start) begin
      repeat (5) tick();
      start = 1'b1; tick(); start = 1'b0;
      pre = 7;
    end
`ifdef AMBIENT_SUBTRACT_EN
    c0 = show_cnt;
    wait_pulse(1'b1, ok, lat);
    check("dark_seen", 32'(ok), 32'd1);
    if (!ok) return;
    check("clear_latency", 32'(pre + lat), 32'(NPIX + 1));
    check("dark_before_show", 32'(show_cnt - c0), 32'd0);
    pulse_done();
    repeat (SETTLE) send_frame(bright, gaps, NPIX);
    send_frame(base_val, gaps, NPIX);
    pre = -1;
`endif
    for (int j = IDB - 1; j >= 0; j--) begin
      wait_pulse(1'b0, ok, lat);
      check("show_seen", 32'(ok), 32'd1);
      if (!ok) return;
      if (j == IDB - 1 && pre > 0) check("clear_latency", 32'(pre + lat), 32'(NPIX + 1));
      check("show_index", 32'(show_bit_index), 32'(j));
      pulse_done();
      repeat (SETTLE) send_frame(bright, gaps, NPIX);
      if (j == abort_bit) begin
        send_frame(frame_val[j], gaps, NPIX / 2);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        c0 = show_cnt;
        repeat (100) tick();
        check("abort_no_show", 32'(show_cnt - c0), 32'd0);
        check("abort_still_idle", 32'(busy | done), 32'd0);
        return;
      end
      send_frame(frame_val[j], gaps, NPIX);
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (done) ok = 1'b1;
    end
    check("done_seen", 32'(ok), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0;
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; show_done = 1'b0; threshold = '0;
    pix_valid = 1'b0; pix_frame_start = 1'b0; pix_addr = '0; pix_data = '0; rd_addr = '0;
    for (int p = 0; p < NPIX; p++) begin
      bright[p] = PW'(255);
      base_val[p] = '0;
    end

    // Reset state
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_show_req", 32'(show_req), 32'd0);
    check("rst_index", 32'(show_bit_index), 32'd0);
    rst = 1'b0; tick();

    // Reset mid-CLEAR
    threshold = PW'(100); start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    rst = 1'b1; repeat (3) tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_show_req", 32'(show_req), 32'd0);
    check("midrst_index", 32'(show_bit_index), 32'd0);
    rst = 1'b0;
    c0 = show_cnt;
    repeat (60) tick();
    check("midrst_no_show", 32'(show_cnt - c0), 32'd0);

    // Full directed run, with a start pulse while busy
    for (int j = 0; j < IDB; j++)
      for (int p = 0; p < NPIX; p++) frame_val[j][p] = PW'(50);
    frame_val[2][5] = PW'(200);
    frame_val[0][5] = PW'(200);
    show_idx_q.delete();
    c0 = show_cnt; d0 = dark_cnt;
    run_cal(100, 1'b0, -1, 1'b1);
    check("full_show_count", 32'(show_cnt - c0), 32'd3);
    check("full_show_q_size", 32'(show_idx_q.size()), 32'd3);
    if (show_idx_q.size() == 3) begin
      check("full_idx0", 32'(show_idx_q[0]), 32'd2);
      check("full_idx1", 32'(show_idx_q[1]), 32'd1);
      check("full_idx2", 32'(show_idx_q[2]), 32'd0);
    end
`ifdef AMBIENT_SUBTRACT_EN
    check("full_dark_count", 32'(dark_cnt - d0), 32'd1);
`else
    check("full_dark_count", 32'(dark_cnt - d0), 32'd0);
`endif
    rd_addr = AW'(5); tick(); tick();
    check("full_pixel5", 32'(rd_data), 32'b101);
    read_table("full", 100);

    // Settle frames are bright, capture frames dark: table must be all zero
    for (int j = 0; j < IDB; j++)
      for (int p = 0; p < NPIX; p++) frame_val[j][p] = '0;
    run_cal(100, 1'b0, -1, 1'b0);
    read_table("settle", 100);

    // Threshold boundary and random data, with and without gaps
    for (int j = 0; j < IDB; j++)
      for (int p = 0; p < NPIX; p++) begin
        int r = $urandom_range(0, 3);
        frame_val[j][p] = (r == 3) ? PW'($urandom_range(0, 300)) : PW'(99 + r);
      end
    frame_val[0][0] = PW'(100);
    frame_val[0][1] = PW'(101);
    run_cal(100, 1'b1, -1, 1'b0);
    read_table("gaps", 100);
    run_cal(100, 1'b0, -1, 1'b0);
    read_table("nogaps", 100);
    rd_addr = AW'(0); tick(); tick();
    check("thr_equal_is_zero", 32'(rd_data[0]), 32'd0);
    rd_addr = AW'(1); tick(); tick();
    check("thr_above_is_one", 32'(rd_data[0]), 32'd1);

    begin
      int thr = $urandom_range(20, 250);
      for (int j = 0; j < IDB; j++)
        for (int p = 0; p < NPIX; p++) frame_val[j][p] = PW'($urandom_range(0, 300));
      run_cal(thr, 1'b1, -1, 1'b0);
      read_table("rand", thr);
    end

`ifdef AMBIENT_SUBTRACT_EN
    // Ambient subtraction: 200-150=50 vs 40/60; 200-220 saturates to 0
    for (int p = 0; p < NPIX; p++) begin
      base_val[p] = PW'(150);
      for (int j = 0; j < IDB; j++) frame_val[j][p] = PW'(200);
    end
    base_val[1] = PW'(220);
    run_cal(40, 1'b1, -1, 1'b0);
    rd_addr = AW'(0); tick(); tick();
    check("amb_thr40", 32'(rd_data), 32'b111);
    rd_addr = AW'(1); tick(); tick();
    check("amb_saturate", 32'(rd_data), 32'b000);
    read_table("amb40", 40);
    run_cal(60, 1'b0, -1, 1'b0);
    rd_addr = AW'(0); tick(); tick();
    check("amb_thr60", 32'(rd_data), 32'b000);
    read_table("amb60", 60);
`endif

    // Abort during capture of bit 1
    run_cal(100, 1'b1, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #3000000;
    tests_failed++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule
